sdm_ctrl: RTL and testbench

Sequencing controller for the 3-stage MASH sigma-delta modulator. It owns the modulator's input word and clear line:
- brings the modulator out of clear with a fixed flush interval;
- accepts new frequency words over a valid/ready handshake;
- ramps the input toward each new word in bounded steps, so the modulator integrators never see a large input jump;
- waits a programmable settling interval, then signals completion.

It sits between the host/register interface and the modulator's `din`/reset inputs.

---
 rtl/sdm_ctrl.sv | 153 +++++++++++++++
 tb/tb_sdm_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sdm_ctrl.sv
// Sequencing controller for a 3-stage MASH sigma-delta modulator: flushes on enable,
// accepts frequency words, ramps sdm_din toward each word in bounded steps, then settles.
module sdm_ctrl #(
    parameter int W         = 16,
    parameter int FLUSH_CYC = 4,
    parameter int SETTLE_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [W-1:0]        cfg_word,
    input  logic [W-1:0]        cfg_step,
    input  logic [SETTLE_W-1:0] cfg_settle,
    output logic [W-1:0]        sdm_din,
    output logic                sdm_clr,
    output logic                busy,
    output logic                done
);

    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_FLUSH  = 3'd1;
    localparam logic [2:0] ST_READY  = 3'd2;
    localparam logic [2:0] ST_RAMP   = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [W-1:0]        din_q, din_d;
    logic                clr_q, clr_d;
    logic                done_q, done_d;
    logic [W-1:0]        target_q, target_d;
    logic [W-1:0]        step_q, step_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SETTLE_W-1:0] scnt_q, scnt_d;
    logic [FW-1:0]       fcnt_q, fcnt_d;

    logic         accept;
    logic [W-1:0] tgt, stp, ramp_next;
    logic [W:0]   delta;
    logic         up, ramp_hit;

    assign cfg_ready = (state_q == ST_OFF) || (state_q == ST_READY);
    assign busy      = (state_q == ST_FLUSH) || (state_q == ST_RAMP) || (state_q == ST_SETTLE);
    assign accept    = cfg_valid & cfg_ready;
    assign sdm_din   = din_q;
    assign sdm_clr   = clr_q;
    assign done      = done_q;

    // In READY the first step uses the word being accepted this edge, not the latched copy.
    always_comb begin
        tgt = (state_q == ST_READY) ? cfg_word : target_q;
        stp = (state_q == ST_READY) ? cfg_step : step_q;
        up  = tgt > din_q;
        delta = up ? ({1'b0, tgt} - {1'b0, din_q}) : ({1'b0, din_q} - {1'b0, tgt});
        ramp_hit  = (stp == '0) || (delta <= {1'b0, stp});
        ramp_next = ramp_hit ? tgt : (up ? din_q + stp : din_q - stp);
    end

    always_comb begin
        state_d  = state_q;
        din_d    = din_q;
        done_d   = 1'b0;
        target_d = target_q;
        step_d   = step_q;
        settle_d = settle_q;
        scnt_d   = scnt_q;
        fcnt_d   = fcnt_q;

        if (accept) begin
            target_d = cfg_word;
            step_d   = cfg_step;
            settle_d = cfg_settle;
        end

        case (state_q)
            ST_OFF: begin
                if (accept) din_d = cfg_word;
                if (en) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FW'(FLUSH_CYC - 1);
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) state_d = ST_READY;
                else fcnt_d = fcnt_q - 1'b1;
            end
            ST_READY: begin
                if (accept) begin
                    din_d = ramp_next;
                    if (ramp_hit) begin
                        state_d = ST_SETTLE;
                        scnt_d  = cfg_settle;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end
            end
            ST_RAMP: begin
                din_d = ramp_next;
                if (ramp_hit) begin
                    state_d = ST_SETTLE;
                    scnt_d  = settle_q;
                end
            end
            ST_SETTLE: begin
                if (scnt_q == '0) begin
                    state_d = ST_READY;
                    done_d  = 1'b1;
                end else begin
                    scnt_d = scnt_q - 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase

        // Disable aborts everything in flight and freezes the modulator input.
        if (!en && state_q != ST_OFF) begin
            state_d = ST_OFF;
            din_d   = din_q;
            done_d  = 1'b0;
        end

        clr_d = (state_d == ST_OFF) || (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_OFF;
            din_q    <= '0;
            clr_q    <= 1'b1;
            done_q   <= 1'b0;
            target_q <= '0;
            step_q   <= '0;
            settle_q <= '0;
            scnt_q   <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            clr_q    <= clr_d;
            done_q   <= done_d;
            target_q <= target_d;
            step_q   <= step_d;
            settle_q <= settle_d;
            scnt_q   <= scnt_d;
            fcnt_q   <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_sdm_ctrl.sv
// Directed, table-driven bench for sdm_ctrl (W=16, FLUSH_CYC=4, SETTLE_W=8).
module tb_sdm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_word = '0;
    logic [15:0] cfg_step = '0;
    logic [7:0]  cfg_settle = '0;
    logic [15:0] sdm_din;
    logic        sdm_clr;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdm_ctrl #(
        .W         (16),
        .FLUSH_CYC (4),
        .SETTLE_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_word   (cfg_word),
        .cfg_step   (cfg_step),
        .cfg_settle (cfg_settle),
        .sdm_din    (sdm_din),
        .sdm_clr    (sdm_clr),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic        en;
        logic        valid;
        logic [15:0] word;
        logic [15:0] step;
        logic [7:0]  settle;
        logic [15:0] e_din;
        logic        e_clr;
        logic        e_busy;
        logic        e_done;
        logic        e_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [vec %0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input logic [15:0] d, input logic c,
                              input logic b, input logic dn, input logic r);
        check("sdm_din", idx, 32'(sdm_din), 32'(d));
        check("sdm_clr", idx, 32'(sdm_clr), 32'(c));
        check("busy", idx, 32'(busy), 32'(b));
        check("done", idx, 32'(done), 32'(dn));
        check("cfg_ready", idx, 32'(cfg_ready), 32'(r));
    endtask

    initial begin
        // en, valid, word, step, settle | din, clr, busy, done, ready
        // Enable and flush: clr stays high for exactly 4 sampled edges.
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h0000, 1, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h0000, 1, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h0000, 1, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h0000, 1, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h0000, 0, 0, 0, 1});
        // Preset din = 0x1000, then jump to 0x1234 with settle 3.
        vecs.push_back('{1, 1, 16'h1000, 16'h0000, 8'd0, 16'h1000, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h1000, 0, 0, 1, 1});
        vecs.push_back('{1, 1, 16'h1234, 16'h0000, 8'd3, 16'h1234, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h1234, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h1234, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h1234, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h1234, 0, 0, 1, 1});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h1234, 0, 0, 0, 1});
        // Back to 0, then ramp up 0x0100 steps to 0x0250 (inputs scrambled mid-ramp).
        vecs.push_back('{1, 1, 16'h0000, 16'h0000, 8'd0, 16'h0000, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h0000, 0, 0, 1, 1});
        vecs.push_back('{1, 1, 16'h0250, 16'h0100, 8'd0, 16'h0100, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'hAAAA, 16'h0001, 8'd9, 16'h0200, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'hAAAA, 16'h0001, 8'd9, 16'h0250, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h0250, 0, 0, 1, 1});
        // Preset 0x0080, then ramp down by 0x0100: single clamped step to 0.
        vecs.push_back('{1, 1, 16'h0080, 16'h0000, 8'd0, 16'h0080, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h0080, 0, 0, 1, 1});
        vecs.push_back('{1, 1, 16'h0000, 16'h0100, 8'd0, 16'h0000, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h0000, 0, 0, 1, 1});
        // Abort: ramp toward 0x0400, valid held through RAMP, en dropped.
        vecs.push_back('{1, 1, 16'h0400, 16'h0100, 8'd5, 16'h0100, 0, 1, 0, 0});
        vecs.push_back('{1, 1, 16'h0055, 16'h0000, 8'd0, 16'h0200, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 16'h0055, 16'h0000, 8'd0, 16'h0200, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 16'h0055, 16'h0000, 8'd0, 16'h0055, 1, 0, 0, 1});
        vecs.push_back('{0, 0, 16'h0000, 16'h0000, 8'd0, 16'h0055, 1, 0, 0, 1});
        // Simultaneous accept of 0xFFFF and enable in OFF, then flush.
        vecs.push_back('{1, 1, 16'hFFFF, 16'h0000, 8'd0, 16'hFFFF, 1, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'hFFFF, 1, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'hFFFF, 1, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'hFFFF, 1, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'hFFFF, 0, 0, 0, 1});
        // Ramp 0xFFFF -> 0x0000 by 0x8000: 0x7FFF then clamp; settle 1.
        vecs.push_back('{1, 1, 16'h0000, 16'h8000, 8'd1, 16'h7FFF, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h0000, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h0000, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h0000, 0, 0, 1, 1});
        // Leave a long settle in flight for the asynchronous reset check.
        vecs.push_back('{1, 1, 16'h0300, 16'h0000, 8'd9, 16'h0300, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 16'h0000, 16'h0000, 8'd0, 16'h0300, 0, 1, 0, 0});

        // Power-on reset, asserted between edges.
        #1 rst = 1'b1;
        #1 check_outs(-1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check_outs(-2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            en         = vecs[i].en;
            cfg_valid  = vecs[i].valid;
            cfg_word   = vecs[i].word;
            cfg_step   = vecs[i].step;
            cfg_settle = vecs[i].settle;
            @(posedge clk);
            #1 check_outs(i, vecs[i].e_din, vecs[i].e_clr, vecs[i].e_busy, vecs[i].e_done,
                          vecs[i].e_ready);
        end

        // Mid-cycle reset during SETTLE must clear outputs without a clock edge.
        cfg_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_outs(-3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b0;
        en = 1'b0;
        @(posedge clk);
        #1 check_outs(-4, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
